i2c_cfg_seq: RTL

- Register-initialisation sequencer that sits directly upstream of the I2C master in the audio-codec path.
- On a start request it walks an internal table of 16-bit codec words: bits 15:9 are the register address and bits 8:0 are the register data.
- It hands each word to the I2C master with a one-cycle request and waits for completion before issuing the next.
- Handles NACK retry, inter-transfer gap and a power-up delay, then reports done or error to the control logic.

---
 rtl/i2c_cfg_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/i2c_cfg_seq.sv
// Codec register-initialisation sequencer: walks a 16-entry word ROM into the I2C master
// with power-up delay, inter-transfer gap and NACK retry. Define I2C_CFG_SEQ_TIMEOUT_EN for a WAIT_DONE watchdog.
module i2c_cfg_seq #(
    parameter int NUM_WORDS      = 10,
    parameter int PWR_DELAY      = 1000,
    parameter int GAP_CYCLES     = 50,
    parameter int RETRY_MAX      = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        xfer_req,
    output logic [15:0] xfer_data,
    input  logic        xfer_done,
    input  logic        xfer_nack,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [3:0]  word_idx
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PWR_WAIT  = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    // One counter serves the power-up wait, the gap and the watchdog; it is sized for the largest.
    localparam int CNT_PG  = (PWR_DELAY > GAP_CYCLES) ? PWR_DELAY : GAP_CYCLES;
    localparam int CNT_MAX = (CNT_PG > TIMEOUT_CYCLES) ? CNT_PG : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    localparam logic [3:0]  LAST_IDX  = 4'(NUM_WORDS - 1);
    localparam logic [7:0]  RETRY_LIM = 8'(RETRY_MAX);

    // Entry 15 sits at the MSB end, entry 0 at the LSB end.
    localparam logic [16*16-1:0] TABLE_INIT = {
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h1201, 16'h0479, 16'h0217, 16'h0017, 16'h1000,
        16'h0A06, 16'h0812, 16'h0E01, 16'h0C10, 16'h1E00
    };

    logic [15:0] rom_words [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rom
            assign rom_words[gi] = TABLE_INIT[gi*16 +: 16];
        end
    endgenerate

    logic [2:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       retry_reg;
    logic [3:0]       word_idx_reg;
    logic [15:0]      xfer_data_reg;
    logic             xfer_req_reg;
    logic             cfg_done_reg;
    logic             cfg_err_reg;
    logic             start_q_reg;
    logic             last_ok_reg;

    logic start_edge;
    logic pwr_expired;
    logic gap_expired;
    logic resp_next;
    logic resp_nack_next;

    assign start_edge  = start & ~start_q_reg;
    assign pwr_expired = (PWR_DELAY <= 1) || (cnt_reg == CNT_W'(PWR_DELAY - 1));
    assign gap_expired = (GAP_CYCLES <= 1) || (cnt_reg == CNT_W'(GAP_CYCLES - 1));

`ifdef I2C_CFG_SEQ_TIMEOUT_EN
    logic timeout_hit;
    // A watchdog expiry is handled as a NACK; a real completion in the same cycle takes priority.
    assign timeout_hit    = (TIMEOUT_CYCLES <= 1) || (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign resp_next      = xfer_done | timeout_hit;
    assign resp_nack_next = xfer_done ? xfer_nack : 1'b1;
`else
    assign resp_next      = xfer_done;
    assign resp_nack_next = xfer_nack;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            word_idx_reg  <= '0;
            xfer_data_reg <= '0;
            xfer_req_reg  <= 1'b0;
            cfg_done_reg  <= 1'b0;
            cfg_err_reg   <= 1'b0;
            start_q_reg   <= 1'b0;
            last_ok_reg   <= 1'b0;
        end else begin
            start_q_reg  <= start;
            xfer_req_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_edge) begin
                        word_idx_reg <= '0;
                        retry_reg    <= '0;
                        cnt_reg      <= '0;
                        cfg_done_reg <= 1'b0;
                        cfg_err_reg  <= 1'b0;
                        state_reg    <= S_PWR_WAIT;
                    end
                end
                S_PWR_WAIT: begin
                    if (pwr_expired) state_reg <= S_ISSUE;
                    else             cnt_reg   <= cnt_reg + 1'b1;
                end
                S_ISSUE: begin
                    xfer_req_reg  <= 1'b1;
                    xfer_data_reg <= rom_words[word_idx_reg];
                    cnt_reg       <= '0;
                    state_reg     <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (resp_next) begin
                        cnt_reg <= '0;
                        if (!resp_nack_next) begin
                            last_ok_reg <= 1'b1;
                            state_reg   <= S_GAP;
                        end else if (retry_reg < RETRY_LIM) begin
                            retry_reg   <= retry_reg + 1'b1;
                            last_ok_reg <= 1'b0;
                            state_reg   <= S_GAP;
                        end else begin
                            cfg_err_reg <= 1'b1;
                            state_reg   <= S_ERROR;
                        end
                    end
`ifdef I2C_CFG_SEQ_TIMEOUT_EN
                    else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (!gap_expired) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (last_ok_reg && word_idx_reg == LAST_IDX) begin
                        cfg_done_reg <= 1'b1;
                        state_reg    <= S_DONE;
                    end else begin
                        if (last_ok_reg) begin
                            word_idx_reg <= word_idx_reg + 1'b1;
                            retry_reg    <= '0;
                        end
                        state_reg <= S_ISSUE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign xfer_req  = xfer_req_reg;
    assign xfer_data = xfer_data_reg;
    assign busy      = !(state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERROR);
    assign cfg_done  = cfg_done_reg;
    assign cfg_err   = cfg_err_reg;
    assign word_idx  = word_idx_reg;

endmodule
